// File: rtl/tile_pkg.sv
// tile_pkg: shared tile-code layout, reveal default and FSM encoding for the tile-match sequencer
package tile_pkg;
  localparam int TILE_W = 11;
  localparam int COLOR_MSB = 6;
  localparam int COLOR_LSB = 1;
  localparam int FLIP_BIT = 0;
  localparam int REVEAL_CYCLES_DEF = 100000000;
  typedef enum logic [2:0] {OFF, WAIT_FIRST, WAIT_SECOND, REVEAL, COMMIT, DONE} state_t;
endpackage

// File: rtl/reveal_timer.sv
// reveal_timer: reveal-window down-counter; clk, clear (sync active-low), clr_i, load_i, run_i, skip_i -> done_o
module reveal_timer #(
  parameter int CYCLES = 4
) (
  input  logic clk,
  input  logic clear,
  input  logic clr_i,
  input  logic load_i,
  input  logic run_i,
  input  logic skip_i,
  output logic done_o
);
  localparam int CW = CYCLES > 1 ? $clog2(CYCLES) : 1;
  logic [CW-1:0] cnt_q, cnt_d;
  always_comb cnt_d = clr_i ? '0 : load_i ? CW'(CYCLES - 1) : (run_i && cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
  always_ff @(posedge clk) cnt_q <= !clear ? '0 : cnt_d;
  assign done_o = run_i && (cnt_q == '0 || skip_i);
endmodule

// File: rtl/tile_match_sequencer.sv
// tile_match_sequencer: sequences pick, timed reveal and commit of one tile-matching round
// Ports: CLOCK_50 clock, clear sync active-low reset, game_en/quit/sel_btn controls, SW picks,
// tile_codes flat code bus -> matched_mask, shown_mask, first_code, second_code, score,
// reveal_active, match_pulse, miss_pulse, game_over, won (all registered).
// Define TILE_SEQ_ATTEMPT_LIMIT_EN to end the game once score reaches MAX_ATTEMPTS.
module tile_match_sequencer
  import tile_pkg::*;
#(
  parameter int NUM_TILES = 10,
  parameter int TILE_W = tile_pkg::TILE_W,
  parameter int REVEAL_CYCLES = REVEAL_CYCLES_DEF,
  parameter int SCORE_W = 8,
  parameter int MAX_ATTEMPTS = 40
) (
  input  logic                          CLOCK_50,
  input  logic                          clear,
  input  logic                          game_en,
  input  logic                          quit,
  input  logic                          sel_btn,
  input  logic [NUM_TILES-1:0]          SW,
  input  logic [NUM_TILES*TILE_W-1:0]   tile_codes,
  output logic [NUM_TILES-1:0]          matched_mask,
  output logic [NUM_TILES-1:0]          shown_mask,
  output logic [TILE_W-1:0]             first_code,
  output logic [TILE_W-1:0]             second_code,
  output logic [SCORE_W-1:0]            score,
  output logic                          reveal_active,
  output logic                          match_pulse,
  output logic                          miss_pulse,
  output logic                          game_over,
  output logic                          won
);
  localparam int IW = NUM_TILES > 1 ? $clog2(NUM_TILES) : 1;
  state_t state_q, state_d;
  logic sel_q, sel_edge, abort, pick_ok, load, t_done, hit;
  logic [IW-1:0] idx1_q, idx1_d, idx2_q, idx2_d, pick_idx;
  logic [TILE_W-1:0] first_q, first_d, second_q, second_d;
  logic [NUM_TILES-1:0] matched_q, matched_d, shown_q, cand;
  logic [SCORE_W-1:0] score_q, score_d;
  logic match_q, match_d, miss_q, miss_d, reveal_q, over_q, won_q;

  function automatic logic [IW:0] lowest(input logic [NUM_TILES-1:0] c);
    lowest = '0;
    for (int i = NUM_TILES - 1; i >= 0; i--) if (c[i]) lowest = {1'b1, IW'(i)};
  endfunction

  function automatic logic [NUM_TILES-1:0] onehot(input logic [IW-1:0] i);
    return NUM_TILES'(1) << i;
  endfunction

  assign sel_edge = sel_btn && !sel_q;
  assign abort = quit || !game_en;
  // the first pick is excluded only while waiting for the second
  assign cand = SW & ~matched_q & (state_q == WAIT_SECOND ? ~onehot(idx1_q) : '1);
  assign {pick_ok, pick_idx} = lowest(cand);
  assign hit = first_q[COLOR_MSB:COLOR_LSB] == second_q[COLOR_MSB:COLOR_LSB];

  reveal_timer #(.CYCLES(REVEAL_CYCLES)) u_timer (
    .clk(CLOCK_50),
    .clear(clear),
    .clr_i(state_d == OFF),
    .load_i(load),
    .run_i(state_q == REVEAL),
    .skip_i(sel_edge),
    .done_o(t_done)
  );

  always_comb begin
    state_d = state_q;
    idx1_d = idx1_q;
    idx2_d = idx2_q;
    first_d = first_q;
    second_d = second_q;
    matched_d = matched_q;
    score_d = score_q;
    match_d = 1'b0;
    miss_d = 1'b0;
    load = 1'b0;
    case (state_q)
      OFF: state_d = game_en ? WAIT_FIRST : OFF;
      WAIT_FIRST: if (sel_edge && pick_ok) begin
        idx1_d = pick_idx;
        first_d = tile_codes[pick_idx*TILE_W +: TILE_W];
        state_d = WAIT_SECOND;
      end
      WAIT_SECOND: if (sel_edge && pick_ok) begin
        idx2_d = pick_idx;
        second_d = tile_codes[pick_idx*TILE_W +: TILE_W];
        load = 1'b1;
        state_d = REVEAL;
      end
      REVEAL: state_d = t_done ? COMMIT : REVEAL;
      COMMIT: begin
        score_d = &score_q ? score_q : score_q + 1'b1;
        matched_d = hit ? matched_q | onehot(idx1_q) | onehot(idx2_q) : matched_q;
        match_d = hit;
        miss_d = !hit;
        first_d = '0;
        second_d = '0;
`ifdef TILE_SEQ_ATTEMPT_LIMIT_EN
        state_d = (&matched_d || score_d == SCORE_W'(MAX_ATTEMPTS)) ? DONE : WAIT_FIRST;
`else
        state_d = &matched_d ? DONE : WAIT_FIRST;
`endif
      end
      DONE: state_d = DONE;
      default: state_d = OFF;
    endcase
    if (abort && state_q != OFF) state_d = OFF;
    // entering or staying in OFF wipes the round exactly like reset
    if (state_d == OFF) begin
      idx1_d = '0;
      idx2_d = '0;
      first_d = '0;
      second_d = '0;
      matched_d = '0;
      score_d = '0;
      match_d = 1'b0;
      miss_d = 1'b0;
    end
  end

`ifndef TILE_SEQ_ATTEMPT_LIMIT_EN
  logic unused_max;
  assign unused_max = |MAX_ATTEMPTS;
`endif

  always_ff @(posedge CLOCK_50) begin
    if (!clear) begin
      state_q <= OFF;
      sel_q <= 1'b0;
      idx1_q <= '0;
      idx2_q <= '0;
      first_q <= '0;
      second_q <= '0;
      matched_q <= '0;
      score_q <= '0;
      match_q <= 1'b0;
      miss_q <= 1'b0;
      shown_q <= '0;
      reveal_q <= 1'b0;
      over_q <= 1'b0;
      won_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q <= sel_btn;
      idx1_q <= idx1_d;
      idx2_q <= idx2_d;
      first_q <= first_d;
      second_q <= second_d;
      matched_q <= matched_d;
      score_q <= score_d;
      match_q <= match_d;
      miss_q <= miss_d;
      shown_q <= matched_d
        | (state_d inside {WAIT_SECOND, REVEAL, COMMIT} ? onehot(idx1_d) : '0)
        | (state_d inside {REVEAL, COMMIT} ? onehot(idx2_d) : '0);
      reveal_q <= state_d == REVEAL;
      over_q <= state_d == DONE;
      won_q <= state_d == DONE && &matched_d;
    end
  end

  assign matched_mask = matched_q;
  assign shown_mask = shown_q;
  assign first_code = first_q;
  assign second_code = second_q;
  assign score = score_q;
  assign reveal_active = reveal_q;
  assign match_pulse = match_q;
  assign miss_pulse = miss_q;
  assign game_over = over_q;
  assign won = won_q;
endmodule

// File: tb/tb_tile_match_sequencer.sv
// tb_tile_match_sequencer: randomized scoreboard bench for tile_match_sequencer
module tb_tile_match_sequencer;
  localparam int N = 10, TW = 11, RC = 4, SCW = 8, MAXA = 3;
  localparam int P_WF = 1, P_WS = 2, P_RV = 3, P_DN = 4;
`ifdef TILE_SEQ_ATTEMPT_LIMIT_EN
  localparam bit LIM = 1'b1;
`else
  localparam bit LIM = 1'b0;
`endif
  typedef struct {bit hit; logic [N-1:0] mask; int score; bit over; bit won;} exp_t;

  logic clk = 1'b0, clear = 1'b0, game_en = 1'b0, quit = 1'b0, sel_btn = 1'b0;
  logic [N-1:0] sw = '0;
  logic [N*TW-1:0] codes;
  logic [N-1:0] matched_mask, shown_mask;
  logic [TW-1:0] first_code, second_code;
  logic [SCW-1:0] score;
  logic reveal_active, match_pulse, miss_pulse, game_over, won;

  int vectors = 0, miscompares = 0;
  int pid[N] = '{0, 1, 2, 3, 1, 3, 2, 0, 4, 4};
  logic [TW-1:0] tc[N];
  logic [N-1:0] m_mask;
  int m_score, m_first, m_second, phase;
  exp_t q[$];
  exp_t e_mon;

  always #5 clk = ~clk;

  tile_match_sequencer #(
    .NUM_TILES(N), .TILE_W(TW), .REVEAL_CYCLES(RC), .SCORE_W(SCW), .MAX_ATTEMPTS(MAXA)
  ) dut (
    .CLOCK_50(clk), .clear(clear), .game_en(game_en), .quit(quit), .sel_btn(sel_btn),
    .SW(sw), .tile_codes(codes), .matched_mask(matched_mask), .shown_mask(shown_mask),
    .first_code(first_code), .second_code(second_code), .score(score),
    .reveal_active(reveal_active), .match_pulse(match_pulse), .miss_pulse(miss_pulse),
    .game_over(game_over), .won(won)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) if (match_pulse || miss_pulse) begin
    if (q.size() == 0) chk("unexpected_pulse", {match_pulse, miss_pulse}, 0);
    else begin
      e_mon = q.pop_front();
      chk("pulse", {match_pulse, miss_pulse}, {e_mon.hit, !e_mon.hit});
      chk("commit_mask", matched_mask, e_mon.mask);
      chk("commit_shown", shown_mask, e_mon.mask);
      chk("commit_score", score, e_mon.score);
      chk("commit_codes", {first_code, second_code}, 0);
      chk("commit_over", {game_over, won}, {e_mon.over, e_mon.won});
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [N-1:0] bit_of(input int i);
    return i < 0 ? '0 : N'(1) << i;
  endfunction

  function automatic int pick_of(input logic [N-1:0] s);
    for (int i = 0; i < N; i++) if (s[i] && !m_mask[i] && i != m_first) return i;
    return -1;
  endfunction

  function automatic int partner(input int a);
    for (int j = 0; j < N; j++) if (j != a && pid[j] == pid[a]) return j;
    return -1;
  endfunction

  task automatic reset_model();
    m_mask = '0;
    m_score = 0;
    m_first = -1;
    m_second = -1;
    phase = P_WF;
  endtask

  task automatic chk_zero(input string nm);
    chk(nm, {matched_mask, shown_mask, first_code, second_code, score,
             reveal_active, match_pulse, miss_pulse, game_over, won}, 0);
  endtask

  task automatic press(input logic [N-1:0] s);
    int p;
    p = pick_of(s);
    sw = s;
    sel_btn = 1'b0;
    tick();
    sel_btn = 1'b1;
    tick();
    sel_btn = 1'b0;
    if (phase == P_WF && p >= 0) begin
      m_first = p;
      phase = P_WS;
    end else if (phase == P_WS && p >= 0) begin
      m_second = p;
      phase = P_RV;
    end
    chk("first_code", first_code, (phase == P_WS || phase == P_RV) ? tc[m_first] : 0);
    chk("second_code", second_code, phase == P_RV ? tc[m_second] : 0);
    chk("shown", shown_mask, m_mask | (phase == P_WS || phase == P_RV ? bit_of(m_first) : '0)
                             | (phase == P_RV ? bit_of(m_second) : '0));
    chk("reveal_on", reveal_active, phase == P_RV);
    chk("over_hold", {game_over, won}, {phase == P_DN, phase == P_DN && &m_mask});
  endtask

  task automatic reveal(input int skip_at, input bit abort);
    int rc = 0;
    bit hit, over;
    exp_t e;
    if (!abort) begin
      hit = pid[m_first] == pid[m_second];
      if (hit) m_mask |= bit_of(m_first) | bit_of(m_second);
      m_score = m_score < 255 ? m_score + 1 : 255;
      over = &m_mask || (LIM && m_score == MAXA);
      e = '{hit, m_mask, m_score, over, &m_mask};
      q.push_back(e);
      phase = over ? P_DN : P_WF;
      m_first = -1;
      m_second = -1;
    end
    while (reveal_active && rc < 50) begin
      rc++;
      sel_btn = skip_at != 0 && rc == skip_at + 1;
      quit = abort && rc == RC;
      tick();
    end
    sel_btn = 1'b0;
    quit = 1'b0;
    chk("reveal_len", rc, (skip_at != 0 && !abort) ? skip_at + 1 : RC);
    if (abort) begin
      chk_zero("abort_reveal");
      reset_model();
    end else tick();
  endtask

  task automatic pair(input int a, input int b, input int skip_at);
    press(bit_of(a));
    press(bit_of(b));
    if (phase == P_RV) reveal(skip_at, 1'b0);
  endtask

  task automatic stop(input bit by_disable);
    if (by_disable) game_en = 1'b0;
    else quit = 1'b1;
    tick();
    chk_zero("stop");
    game_en = 1'b1;
    quit = 1'b0;
    reset_model();
  endtask

  function automatic logic [N-1:0] rand_sw();
    int r = $urandom_range(0, 9);
    if (phase == P_WS && r < 4) return bit_of(partner(m_first));
    if (r < 7) return bit_of($urandom_range(0, N - 1));
    if (r < 9) return N'($urandom);
    return '0;
  endfunction

  initial begin
    for (int i = 0; i < N; i++) begin
      tc[i] = {4'($urandom), 6'(pid[i] * 9 + 5), 1'($urandom)};
      codes[i*TW +: TW] = tc[i];
    end
    reset_model();
    repeat (3) tick();
    chk_zero("reset");
    clear = 1'b1;
    tick();
    chk_zero("off_idle");
    game_en = 1'b1;
    press(10'h000);
    press(10'h003);
    press(10'h001);
    press(10'h010);
    reveal(0, 1'b0);
    pair(0, 7, 0);
    press(10'h081);
    pair(1, 2, 1);
    stop(1'b0);
    pair(0, 7, 0);
    pair(1, 4, 2);
    pair(2, 6, 0);
    pair(3, 5, 3);
    pair(8, 9, 0);
    press(10'h3FF);
    stop(1'b0);
    press(10'h001);
    press(10'h002);
    reveal(0, 1'b1);
    press(10'h004);
    clear = 1'b0;
    tick();
    chk_zero("clear_mid");
    clear = 1'b1;
    reset_model();
    pair(0, 1, 0);
    pair(0, 2, 0);
    pair(0, 3, 0);
    stop(1'b1);
    for (int it = 0; it < 300; it++) begin
      int r;
      bit ab;
      r = $urandom_range(0, 29);
      if (phase == P_DN || r == 0) stop(r[0]);
      else begin
        press(rand_sw());
        ab = $urandom_range(0, 7) == 0;
        if (phase == P_RV) reveal(ab ? 0 : $urandom_range(0, RC - 1), ab);
      end
    end
    repeat (3) tick();
    chk("pending", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
